// File: rtl/sr04_dist_proc.sv
// HC-SR04 back end: echo-fall detect, settled dis capture, sliding average, mm scaling, BCD.
// Optional proximity alarm with hysteresis when SR04_ALARM_EN is defined.
module sr04_dist_proc #(
  parameter int unsigned AVG_LOG2      = 2,
  parameter int unsigned SETTLE_CYC    = 64,
  parameter int unsigned TIMEOUT_CYC   = 1_500_000,
  parameter int unsigned ALARM_NEAR_MM = 300,
  parameter int unsigned ALARM_HYST_MM = 50
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        echo,
  input  logic [12:0] dis,
  output logic [13:0] dist_mm,
  output logic [19:0] dist_bcd,
  output logic        dist_valid,
  output logic        timeout_err
`ifdef SR04_ALARM_EN
  ,
  output logic        alarm
`endif
);

  localparam int unsigned WIN     = 1 << AVG_LOG2;
  localparam int unsigned SUM_W   = 13 + AVG_LOG2;
  localparam int unsigned WP_W    = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int unsigned CNT_MAX = (TIMEOUT_CYC > SETTLE_CYC) ? TIMEOUT_CYC : SETTLE_CYC;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {IDLE, HIGH, WAITLO, SETTLE, ACCUM, SCALE, CONV, DONE} state_t;
  state_t state, state_nx;

  logic              echo_s1, echo_s2, echo_s3;
  logic              rise, fall;
  logic [CNT_W-1:0]  cnt;
  logic              to_hit, st_hit;
  logic [3:0]        bit_cnt;
  logic [12:0]       dis_cap;
  logic [12:0]       win_buf [WIN];
  logic [WP_W-1:0]   wp;
  logic [AVG_LOG2:0] fill, fill_nx;
  logic [SUM_W-1:0]  sum;
  logic [12:0]       avg;
  logic [13:0]       mm_calc, mm_r, bin_sh;
  logic [19:0]       bcd_sh;
  logic [18:0]       bcd_adj;

  assign rise    = echo_s2 & ~echo_s3;
  assign fall    = ~echo_s2 & echo_s3;
  assign to_hit  = (cnt == CNT_W'(TIMEOUT_CYC - 1));
  assign st_hit  = (cnt == CNT_W'(SETTLE_CYC - 1));
  assign fill_nx = (fill == (AVG_LOG2+1)'(WIN)) ? fill : fill + 1'b1;
  assign avg     = 13'(sum >> AVG_LOG2);
  // 355/256 ~= 1.3867 mm per count; floor by dropping the fraction bits
  assign mm_calc = 14'((22'(avg) * 22'd355) >> 8);

  // Double-dabble add-3 on the four low digits; the top digit never exceeds 1.
  always_comb begin
    bcd_adj = bcd_sh[18:0];
    for (int i = 0; i < 4; i++)
      if (bcd_sh[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_sh[4*i +: 4] + 4'd3;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (rise) state_nx = HIGH;
      HIGH:    if (fall) state_nx = SETTLE;
               else if (to_hit) state_nx = WAITLO;
      WAITLO:  if (fall) state_nx = IDLE;
      SETTLE:  if (st_hit) state_nx = ACCUM;
      ACCUM:   state_nx = (fill_nx == (AVG_LOG2+1)'(WIN)) ? SCALE : IDLE;
      SCALE:   state_nx = CONV;
      CONV:    if (bit_cnt == 4'd13) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      echo_s1     <= 1'b0;
      echo_s2     <= 1'b0;
      echo_s3     <= 1'b0;
      cnt         <= '0;
      bit_cnt     <= '0;
      dis_cap     <= '0;
      for (int i = 0; i < WIN; i++) win_buf[i] <= '0;
      wp          <= '0;
      fill        <= '0;
      sum         <= '0;
      mm_r        <= '0;
      bin_sh      <= '0;
      bcd_sh      <= '0;
      dist_mm     <= '0;
      dist_bcd    <= '0;
      dist_valid  <= 1'b0;
      timeout_err <= 1'b0;
`ifdef SR04_ALARM_EN
      alarm       <= 1'b0;
`endif
    end else begin
      echo_s1    <= echo;
      echo_s2    <= echo_s1;
      echo_s3    <= echo_s2;
      dist_valid <= 1'b0;
      case (state)
        IDLE: cnt <= '0;
        HIGH: begin
          if (fall)        cnt <= '0;
          else if (to_hit) timeout_err <= 1'b1;
          else             cnt <= cnt + 1'b1;
        end
        SETTLE: begin
          if (st_hit) dis_cap <= dis;
          else        cnt <= cnt + 1'b1;
        end
        ACCUM: begin
          // Oldest slot is replaced; zeroed slots make the partial-fill sum exact.
          sum         <= sum - SUM_W'(win_buf[wp]) + SUM_W'(dis_cap);
          win_buf[wp] <= dis_cap;
          wp          <= (wp == WP_W'(WIN - 1)) ? '0 : wp + 1'b1;
          fill        <= fill_nx;
        end
        SCALE: begin
          mm_r    <= mm_calc;
          bin_sh  <= mm_calc;
          bcd_sh  <= '0;
          bit_cnt <= '0;
        end
        CONV: begin
          bcd_sh  <= {bcd_adj, bin_sh[13]};
          bin_sh  <= {bin_sh[12:0], 1'b0};
          bit_cnt <= bit_cnt + 1'b1;
        end
        DONE: begin
          dist_mm     <= mm_r;
          dist_bcd    <= bcd_sh;
          dist_valid  <= 1'b1;
          timeout_err <= 1'b0;
`ifdef SR04_ALARM_EN
          if (mm_r < 14'(ALARM_NEAR_MM))                      alarm <= 1'b1;
          else if (mm_r >= 14'(ALARM_NEAR_MM + ALARM_HYST_MM)) alarm <= 1'b0;
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sr04_dist_proc.sv
// Bench for sr04_dist_proc: window-1 and window-4 instances share echo/dis and are checked
// against a queue-based reference of the averaging, mm scaling, BCD, timeout and alarm rules.
module tb_sr04_dist_proc;

  localparam int TO_CYC = 200;

  logic        clk = 1'b0;
  logic        rst, echo;
  logic [12:0] dis;
  logic [13:0] mm0, mm2;
  logic [19:0] bcd0, bcd2;
  logic        v0, v2, err0, err2;
`ifdef SR04_ALARM_EN
  logic        alm0, alm2;
  bit          alm0_m, alm2_m;
`endif

  int checks = 0;
  int failures = 0;
  int q0[$];
  int q2[$];
  bit err0_m, err2_m;

  always #5 clk = ~clk;

  sr04_dist_proc #(.AVG_LOG2(0), .TIMEOUT_CYC(TO_CYC)) u_w1 (
    .clk(clk), .rst(rst), .echo(echo), .dis(dis),
    .dist_mm(mm0), .dist_bcd(bcd0), .dist_valid(v0), .timeout_err(err0)
`ifdef SR04_ALARM_EN
    , .alarm(alm0)
`endif
  );

  sr04_dist_proc #(.AVG_LOG2(2), .TIMEOUT_CYC(TO_CYC)) u_w4 (
    .clk(clk), .rst(rst), .echo(echo), .dis(dis),
    .dist_mm(mm2), .dist_bcd(bcd2), .dist_valid(v2), .timeout_err(err2)
`ifdef SR04_ALARM_EN
    , .alarm(alm2)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int mm_of(input int q[$]);
    int s = 0;
    foreach (q[i]) s += q[i];
    return ((s / q.size()) * 355) / 256;
  endfunction

  function automatic logic [31:0] to_bcd(input int v);
    logic [31:0] r = '0;
    for (int i = 0; i < 5; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  task automatic check_zero(input string tag);
    check({tag, "_mm0"}, mm0, 0);
    check({tag, "_bcd0"}, bcd0, 0);
    check({tag, "_v0"}, v0, 0);
    check({tag, "_err0"}, err0, 0);
    check({tag, "_mm2"}, mm2, 0);
    check({tag, "_bcd2"}, bcd2, 0);
    check({tag, "_v2"}, v2, 0);
    check({tag, "_err2"}, err2, 0);
`ifdef SR04_ALARM_EN
    check({tag, "_alm0"}, alm0, 0);
    check({tag, "_alm2"}, alm2, 0);
`endif
  endtask

  // One echo of hi cycles; dis is stable from before the rise. Watches both valids afterwards.
  task automatic run_echo(input int hi, input int d, input bit timed_out);
    int n0 = 0, n2 = 0, e0 = 0, e2 = 0, m = 0;
    logic [31:0] got_mm0 = '0, got_mm2 = '0, got_b0 = '0, got_b2 = '0;
    @(posedge clk); #1;
    dis  = 13'(d);
    echo = 1'b1;
    repeat (hi) @(posedge clk);
    #1 echo = 1'b0;
    for (int c = 0; c < 130; c++) begin
      @(negedge clk);
      if (v0) begin n0++; got_mm0 = mm0; got_b0 = bcd0; end
      if (v2) begin n2++; got_mm2 = mm2; got_b2 = bcd2; end
    end
    if (timed_out) begin
      err0_m = 1'b1;
      err2_m = 1'b1;
    end else begin
      q0.push_back(d);
      if (q0.size() > 1) void'(q0.pop_front());
      e0 = (q0.size() == 1);
      q2.push_back(d);
      if (q2.size() > 4) void'(q2.pop_front());
      e2 = (q2.size() == 4);
    end
    check("valid_w1", n0, e0);
    check("valid_w4", n2, e2);
    if (e0) begin
      m = mm_of(q0);
      check("mm_w1", got_mm0, m);
      check("bcd_w1", got_b0, to_bcd(m));
      err0_m = 1'b0;
`ifdef SR04_ALARM_EN
      if (m < 300) alm0_m = 1'b1; else if (m >= 350) alm0_m = 1'b0;
`endif
    end
    if (e2) begin
      m = mm_of(q2);
      check("mm_w4", got_mm2, m);
      check("bcd_w4", got_b2, to_bcd(m));
      err2_m = 1'b0;
`ifdef SR04_ALARM_EN
      if (m < 300) alm2_m = 1'b1; else if (m >= 350) alm2_m = 1'b0;
`endif
    end
    check("err_w1", err0, err0_m);
    check("err_w4", err2, err2_m);
`ifdef SR04_ALARM_EN
    check("alarm_w1", alm0, alm0_m);
    check("alarm_w4", alm2, alm2_m);
`endif
  endtask

  initial begin
    int seen;
    rst  = 1'b1;
    echo = 1'b0;
    dis  = '0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check_zero("reset");
    rst = 1'b0;
    repeat (5) @(posedge clk);

    // window fill, steady average, full-scale and nominal samples
    run_echo(20, 100, 0);
    run_echo(35, 200, 0);
    run_echo(12, 300, 0);
    run_echo(60, 400, 0);
    run_echo(25, 500, 0);
    run_echo(40, 8191, 0);
    run_echo(18, 720, 0);

    // echo stuck high past the timeout, then a normal echo clears the flag
    run_echo(TO_CYC + 60, 1234, 1);
    run_echo(30, 720, 0);

    // alarm hysteresis walk: mm 400, 291, 320, 360
    run_echo(22, 289, 0);
    run_echo(22, 210, 0);
    run_echo(22, 231, 0);
    run_echo(22, 260, 0);

    // reset mid-conversion of a full-window result
    @(posedge clk); #1;
    dis  = 13'd720;
    echo = 1'b1;
    repeat (20) @(posedge clk);
    #1 echo = 1'b0;
    seen = 0;
    for (int c = 0; c < 75; c++) begin
      @(negedge clk);
      if (v0 || v2) seen++;
    end
    check("no_valid_before_rst", seen, 0);
    rst = 1'b1;
    @(negedge clk);
    check_zero("rst_conv");
    rst = 1'b0;
    seen = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (v0 || v2) seen++;
    end
    check("no_valid_after_rst", seen, 0);
    q0.delete();
    q2.delete();
    err0_m = 1'b0;
    err2_m = 1'b0;
`ifdef SR04_ALARM_EN
    alm0_m = 1'b0;
    alm2_m = 1'b0;
`endif

    // refill from empty, including a zero sample
    run_echo(15, 0, 0);
    run_echo(15, 8191, 0);
    run_echo(15, 5, 0);
    run_echo(15, 4000, 0);

    for (int k = 0; k < 8; k++)
      run_echo(int'($urandom_range(150, 5)), int'($urandom_range(8191, 0)), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
